// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Upper bound on requesters that onehot() can encode.
  localparam int unsigned MAX_REQ = 32;

  function automatic int unsigned calc_id_w(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after start, wrapping at NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    id_o  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap so non-power-of-2 counts never alias via truncation.
      idx = 32'(start_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        id_o  = idx[ID_W-1:0];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, BURST words per grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned BURST      = 4,
  localparam int unsigned ID_W      = calc_id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_W-1:0]               owner_id,
  output logic                          busy
);

  localparam int unsigned BW = (BURST <= 2) ? 1 : $clog2(BURST);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [ID_W-1:0] rr_q, rr_d;

  logic                  granted;
  logic                  req_own;
  logic [DATA_WIDTH-1:0] data_own;
  logic                  xfer;
  logic                  last_word;
  logic [ID_W-1:0]       owner_inc;
  logic [ID_W-1:0]       pick_start;
  logic                  pick_valid;
  logic [ID_W-1:0]       pick_id;
  logic [MAX_REQ-1:0]    owner_oh;

  assign granted   = (state_q == GRANT);
  assign owner_inc = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign last_word = (burst_q == BW'(BURST - 1));

  always_comb begin
    req_own  = 1'b0;
    data_own = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        req_own  = req[i];
        data_own = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer     = granted & req_own & ~fifo_full;
  assign owner_oh = onehot(32'(owner_q));

  assign gnt          = granted ? owner_oh[NUM_REQ-1:0] : '0;
  assign ack          = owner_oh[NUM_REQ-1:0] & {NUM_REQ{xfer}};
  assign fifo_wr_en   = xfer;
  assign fifo_data_in = granted ? data_own : '0;
  assign owner_id     = granted ? owner_q : '0;
  assign busy         = granted;

  // One picker serves both paths: rr_ptr from IDLE, owner+1 on handoff.
  assign pick_start = granted ? owner_inc : rr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_id;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (xfer && !last_word) burst_d = burst_q + 1'b1;
        if ((xfer && last_word) || !req_own) begin
          rr_d = owner_inc;
          if (pick_valid) begin
            owner_d = pick_id;
            burst_d = '0;
          end else begin
            state_d = IDLE;
            owner_d = '0;
            burst_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      burst_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      rr_q    <= rr_d;
    end
  end

endmodule
